// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch unit.
package mips_fetch_pkg;

    localparam int              FETCH_PC_W = 32;
    localparam logic [31:0]     RESET_PC   = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]           inst;
        logic [FETCH_PC_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_fifo.sv
// Synchronous FIFO with clear; used for the prefetch queue and the outstanding-PC tracker.
module mips_fetch_fifo #(
    parameter int  N  = 4,
    parameter type T  = logic [31:0],
    localparam int AW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          push_i,
    input  T              data_i,
    input  logic          pop_i,
    output T              data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    T              mem_q [N];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(N));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_q];
    // A pop frees the slot for a same-cycle push on a full FIFO.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= inc(wr_q);
            end
            if (do_pop) rd_q <= inc(rd_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, prefetch queue, redirect flush.
// Define MIPS_FETCH_BYPASS_EN to hand a response straight to decode when the queue is empty.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [PC_W-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc
);
    localparam int QCW = $clog2(DEPTH + 1);
    localparam int TCW = $clog2(MAX_OUT + 1);

    fetch_state_t    state_q;
    logic [PC_W-1:0] fetch_pc_q;
    logic [TCW-1:0]  discard_q;

    fetch_entry_t    q_in, q_head;
    logic [QCW-1:0]  q_count;
    logic            q_full, q_empty, q_push, q_pop;
    logic [PC_W-1:0] trk_head;
    logic [TCW-1:0]  trk_count;
    logic            trk_full, trk_empty, trk_pop;

    logic            run, req_fire, rsp_take, bypass;
    logic [TCW-1:0]  inflight, left;
    logic [PC_W-1:0] redir_aligned;

    assign run           = (state_q == S_RUN);
    assign redir_aligned = redirect_pc & ~PC_W'(3);
    // Only one of discard/tracker is ever non-zero, so the sum is the outstanding count.
    assign inflight      = discard_q + trk_count;
    assign left          = inflight - TCW'(imem_rsp_valid && (inflight != '0));

    assign imem_req_valid = run && !redirect_valid && !trk_full
                         && (int'(q_count) + int'(trk_count) < DEPTH);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_take       = run && imem_rsp_valid && !redirect_valid;

`ifdef MIPS_FETCH_BYPASS_EN
    assign bypass = rsp_take && q_empty && inst_ready;
`else
    assign bypass = 1'b0;
`endif

    assign trk_pop    = run && imem_rsp_valid && !trk_empty;
    assign q_in       = '{inst: imem_rsp_data, pc: FETCH_PC_W'(trk_head)};
    assign q_push     = rsp_take && !bypass && (!q_full || q_pop);
    assign q_pop      = inst_valid && inst_ready && !redirect_valid && !bypass;
    assign inst_valid = !q_empty || bypass;
    assign inst_data  = bypass ? imem_rsp_data : q_head.inst;
    assign inst_pc    = bypass ? trk_head : PC_W'(q_head.pc);

    mips_fetch_fifo #(.N(DEPTH), .T(fetch_entry_t)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (redirect_valid),
        .push_i  (q_push),
        .data_i  (q_in),
        .pop_i   (q_pop),
        .data_o  (q_head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    mips_fetch_fifo #(.N(MAX_OUT), .T(logic [PC_W-1:0])) u_trk (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (redirect_valid),
        .push_i  (req_fire),
        .data_i  (fetch_pc_q),
        .pop_i   (trk_pop),
        .data_o  (trk_head),
        .count_o (trk_count),
        .full_o  (trk_full),
        .empty_o (trk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= PC_W'(RESET_PC);
            discard_q  <= '0;
        end else if (redirect_valid) begin
            fetch_pc_q <= redir_aligned;
            discard_q  <= left;
            state_q    <= (left != '0) ? S_FLUSH : S_RUN;
        end else begin
            if (req_fire) fetch_pc_q <= fetch_pc_q + PC_W'(4);
            case (state_q)
                S_BOOT:  state_q <= S_RUN;
                S_FLUSH: if (imem_rsp_valid && discard_q != '0) begin
                    discard_q <= discard_q - 1'b1;
                    if (discard_q == TCW'(1)) state_q <= S_RUN;
                end
                default: ;
            endcase
        end
    end

endmodule
